// File: rtl/controle_timer.sv
// controle_timer: countdown sequencer for a chain of NDIG cascaded BCD
// mod-10 down-counter digits. It collects keypad digits into a BCD preset,
// loads the chain with an active-low strobe, issues one-cycle count enables
// at the prescaled tick rate and flags completion from the digits' zero flags.
//
// Optional feature macro: TIMER_ALARM_EN
//   defined   : DONE holds done/alarm for ALARM_TICKS ticks (any key aborts).
//   undefined : done is a one-cycle pulse and alarm is tied low.
//
// Key interface: key_valid is a one-cycle strobe qualifying key_code; there is
// no back-pressure, every strobe is consumed in the cycle it is sampled and
// keys with no action in the current state are dropped.
//
// state_dbg exposes the FSM state: 0 IDLE, 1 ENTRY, 2 LOAD, 3 RUN, 4 PAUSE,
// 5 DONE.
module controle_timer #(
  parameter int TICK_DIV    = 50000000,
  parameter int NDIG        = 4,
  parameter int ALARM_TICKS = 5
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic [NDIG-1:0]   cnt_zero,
  output logic [4*NDIG-1:0] data,
  output logic              loadn,
  output logic              en,
  output logic              running,
  output logic              done,
  output logic              alarm,
  output logic [2:0]        state_dbg
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Elaboration-time guard against parameter values the logic cannot handle.
  if (TICK_DIV < 2 || NDIG < 2 || ALARM_TICKS < 1) begin : g_param_check
    $error("controle_timer: need TICK_DIV >= 2, NDIG >= 2, ALARM_TICKS >= 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state;
  logic [PW-1:0]       presc;
  logic                key_digit;
  logic                key_start;
  logic                key_stop;
  logic                key_clear;
  logic                tick;
  logic                all_zero;
  logic [4*NDIG-1:0]   data_shift;

`ifdef TIMER_ALARM_EN
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
  logic [AW-1:0]       acnt;
`else
  // Without the alarm feature the alarm drive is permanently inactive.
  assign alarm = 1'b0;
`endif

  // Key decode; each strobe carries a single code so priority only matters
  // through the order of the checks in the FSM below.
  assign key_digit  = key_valid && (key_code <= 4'd9);
  assign key_start  = key_valid && (key_code == 4'hA);
  assign key_stop   = key_valid && (key_code == 4'hB);
  assign key_clear  = key_valid && (key_code == 4'hC);

  // A tick is the prescaler wrap cycle; the zero flags are only looked at here.
  assign tick       = (presc == PRESC_LAST);
  assign all_zero   = &cnt_zero;

  // New digit enters at the least-significant position, oldest digit drops out.
  assign data_shift = {data[4*NDIG-5:0], key_code};

  assign state_dbg  = state;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      data    <= '0;
      loadn   <= 1'b1;
      en      <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
      presc   <= '0;
`ifdef TIMER_ALARM_EN
      alarm   <= 1'b0;
      acnt    <= '0;
`endif
    end else begin
      // en and loadn are single-cycle strobes; they fall back by default.
      en    <= 1'b0;
      loadn <= 1'b1;
      case (state)
        IDLE: begin
          if (key_digit) begin
            data  <= data_shift;
            state <= ENTRY;
          end
        end

        ENTRY: begin
          if (key_clear) begin
            data  <= '0;
            state <= IDLE;
          end else if (key_start) begin
            // An all-zero preset would never produce a pulse; ignore it.
            if (data != '0) begin
              loadn <= 1'b0;
              state <= LOAD;
            end
          end else if (key_digit) begin
            data <= data_shift;
          end
        end

        LOAD: begin
          // loadn is low for this single cycle while en stays low.
          presc   <= '0;
          running <= 1'b1;
          state   <= RUN;
        end

        RUN: begin
          if (key_clear) begin
            data    <= '0;
            running <= 1'b0;
            state   <= IDLE;
          end else if (key_stop) begin
            // Prescaler is left untouched so the tick phase resumes later.
            running <= 1'b0;
            state   <= PAUSE;
          end else if (tick) begin
            presc <= '0;
            if (all_zero) begin
              // No pulse at zero, otherwise the chain would wrap to 9s.
              running <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
`ifdef TIMER_ALARM_EN
              alarm   <= 1'b1;
              acnt    <= '0;
`endif
            end else begin
              en <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end

        PAUSE: begin
          if (key_clear) begin
            data  <= '0;
            state <= IDLE;
          end else if (key_start) begin
            running <= 1'b1;
            state   <= RUN;
          end
        end

        DONE: begin
`ifdef TIMER_ALARM_EN
          if (key_valid) begin
            done  <= 1'b0;
            alarm <= 1'b0;
            state <= IDLE;
          end else if (tick) begin
            presc <= '0;
            if (acnt == ALARM_LAST) begin
              done  <= 1'b0;
              alarm <= 1'b0;
              state <= IDLE;
            end else begin
              acnt <= acnt + 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
`else
          done  <= 1'b0;
          state <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_timer.sv
// Bench for controle_timer with TICK_DIV=4, NDIG=4, ALARM_TICKS=3 and a
// behavioural mod-10 down-counter chain closing the loop on cnt_zero.
module tb_controle_timer;

  localparam int TICK_DIV    = 4;
  localparam int NDIG        = 4;
  localparam int ALARM_TICKS = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

`ifdef TIMER_ALARM_EN
  localparam int DONE_W  = ALARM_TICKS * TICK_DIV;
  localparam int ALARM_W = ALARM_TICKS * TICK_DIV;
`else
  localparam int DONE_W  = 1;
  localparam int ALARM_W = 0;
`endif

  logic              clk = 1'b0;
  logic              clrn = 1'b0;
  logic              key_valid = 1'b0;
  logic [3:0]        key_code = 4'd0;
  logic [NDIG-1:0]   cnt_zero;
  logic [4*NDIG-1:0] data;
  logic              loadn;
  logic              en;
  logic              running;
  logic              done;
  logic              alarm;
  logic [2:0]        state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int en_cnt   = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  controle_timer #(
    .TICK_DIV(TICK_DIV),
    .NDIG(NDIG),
    .ALARM_TICKS(ALARM_TICKS)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .key_valid(key_valid),
    .key_code(key_code),
    .cnt_zero(cnt_zero),
    .data(data),
    .loadn(loadn),
    .en(en),
    .running(running),
    .done(done),
    .alarm(alarm),
    .state_dbg(state_dbg)
  );

  // ---------------- counter chain model ----------------
  logic [3:0]  digit[NDIG];
  logic [15:0] model_cnt;

  always @(posedge clk or negedge clrn) begin : chain
    bit lower;
    if (!clrn) begin
      for (int i = 0; i < NDIG; i++) digit[i] <= 4'd0;
    end else if (!loadn) begin
      for (int i = 0; i < NDIG; i++) digit[i] <= data[4*i +: 4];
    end else if (en) begin
      lower = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
        if (lower) digit[i] <= (digit[i] == 4'd0) ? 4'd9 : digit[i] - 4'd1;
        lower = lower && (digit[i] == 4'd0);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NDIG; i++) cnt_zero[i] = (digit[i] == 4'd0);
    model_cnt = {digit[3], digit[2], digit[1], digit[0]};
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Per-cycle invariants and the en scoreboard (count seen at each pulse).
  bit armed = 1'b0;
  bit reached = 1'b0;
  always @(negedge clk) begin
    check("en_during_load", 32'(en & ~loadn), 32'd0);
    check("en_at_zero", 32'(en & (&cnt_zero)), 32'd0);
    if (!clrn) begin
      armed = 1'b0;
      reached = 1'b0;
    end else if (!loadn) begin
      armed = 1'b1;
      reached = 1'b0;
    end else if (armed && model_cnt == 16'd0) begin
      reached = 1'b1;
    end
    if (reached) check("no_wrap", 32'(model_cnt), 32'd0);
    if (en) begin
      en_cnt++;
      if (exp_q.size() == 0) check("sb_unexpected_en", 32'd1, 32'd0);
      else check("sb_count_at_en", 32'(model_cnt), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic wait_en(input string tag, input int exp_gap);
    int gap;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!en && gap < 50);
    check({tag, "_gap"}, 32'(gap), 32'(exp_gap));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    int dh;
    int ah;

    // Reset values while clrn is held low.
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'd0);
    check("rst_loadn", 32'(loadn), 32'd1);
    check("rst_en", 32'(en), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    clrn = 1'b1;
    @(negedge clk);

    // Entry: 1,2,3,4,5 keeps the last four digits; clear returns to IDLE.
    press(4'd1);
    check("entry_first_data", 32'(data), 32'h0001);
    check("entry_first_state", 32'(state_dbg), 32'(S_ENTRY));
    press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    check("entry_data", 32'(data), 32'h2345);
    press(4'hE);
    check("entry_ignored_key", 32'(data), 32'h2345);
    press(4'hC);
    check("clear_data", 32'(data), 32'd0);
    check("clear_state", 32'(state_dbg), 32'(S_IDLE));

    // Zero start is ignored.
    press(4'd0);
    check("zero_entry_state", 32'(state_dbg), 32'(S_ENTRY));
    press(4'hA);
    check("zero_start_state", 32'(state_dbg), 32'(S_ENTRY));
    cnt = 0;
    repeat (8) begin
      if (!loadn || en) cnt++;
      @(negedge clk);
    end
    check("zero_start_quiet", 32'(cnt), 32'd0);
    press(4'hC);

    // Countdown from 0x0012 with a pause after the third pulse.
    press(4'd1); press(4'd2);
    check("cd_preset", 32'(data), 32'h0012);
    for (int v = 12; v >= 1; v--) exp_q.push_back(to_bcd(v));
    press(4'hA);
    check("cd_loadn_low", 32'(loadn), 32'd0);
    check("cd_load_state", 32'(state_dbg), 32'(S_LOAD));
    check("cd_load_running", 32'(running), 32'd0);
    @(negedge clk);
    check("cd_loadn_high", 32'(loadn), 32'd1);
    check("cd_running", 32'(running), 32'd1);
    check("cd_run_state", 32'(state_dbg), 32'(S_RUN));
    wait_en("cd_first_en", TICK_DIV);
    wait_en("cd_en2", TICK_DIV);
    wait_en("cd_en3", TICK_DIV);
    @(negedge clk);
    press(4'hB);
    check("pause_state", 32'(state_dbg), 32'(S_PAUSE));
    check("pause_running", 32'(running), 32'd0);
    press(4'd7);
    check("pause_digit_ignored", 32'(data), 32'h0012);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (en) cnt++;
    end
    check("pause_no_en", 32'(cnt), 32'd0);
    press(4'hA);
    check("resume_state", 32'(state_dbg), 32'(S_RUN));
    check("resume_running", 32'(running), 32'd1);
    // One prescaler step was spent before the stop, so three remain.
    wait_en("resume_en", TICK_DIV - 1);
    for (int i = 0; i < 8; i++) wait_en("cd_tail_en", TICK_DIV);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!done && cnt < 50);
    check("done_gap", 32'(cnt), 32'(TICK_DIV));
    check("cd_total_en", 32'(en_cnt), 32'd12);
    check("cd_queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_state", 32'(state_dbg), 32'(S_DONE));
    check("done_running", 32'(running), 32'd0);

    // Completion flag / alarm width, then back to IDLE with the preset kept.
    dh = 0;
    ah = 0;
    while ((done || alarm) && dh < 100) begin
      if (done) dh++;
      if (alarm) ah++;
      @(negedge clk);
    end
    check("done_width", 32'(dh), 32'(DONE_W));
    check("alarm_width", 32'(ah), 32'(ALARM_W));
    check("after_done_state", 32'(state_dbg), 32'(S_IDLE));
    check("after_done_data", 32'(data), 32'h0012);

    // Asynchronous reset in the middle of RUN, while en is high.
    press(4'd5);
    check("rerun_preset", 32'(data), 32'h0125);
    exp_q.push_back(16'h0125);
    press(4'hA);
    @(negedge clk);
    wait_en("rerun_first_en", TICK_DIV);
    #2;
    clrn = 1'b0;
    #1;
    check("arst_data", 32'(data), 32'd0);
    check("arst_loadn", 32'(loadn), 32'd1);
    check("arst_en", 32'(en), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_alarm", 32'(alarm), 32'd0);
    check("arst_state", 32'(state_dbg), 32'(S_IDLE));
    @(negedge clk);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_state", 32'(state_dbg), 32'(S_IDLE));
    check("post_rst_data", 32'(data), 32'd0);
    check("post_rst_running", 32'(running), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/controle_timer.md
# controle_timer

Sequencer that drives a chain of NDIG cascaded BCD mod-10 down-counter digits as a countdown timer.
- Collects keypad digits into a BCD preset and loads it into the chain with an active-low load strobe.
- Generates the one-cycle count enable for the least-significant digit at a prescaled tick rate.
- Watches the digits' zero flags and signals completion.
- Sits between the keypad decoder and the counter chain; the counters' `tc` cascade is outside this block.

## Interface
Parameters:
- TICK_DIV, 50000000, clk cycles per countdown tick (≥2).
- NDIG, 4, number of BCD digits in the chain.
- ALARM_TICKS, 5, alarm duration in ticks (used only with TIMER_ALARM_EN).

Ports:
- clk  in  1  rising-edge clock.
- clrn  in  1  asynchronous active-low reset; shared with the counter chain.
- key_valid  in  1  one-cycle key strobe.
- key_code  in  4  0x0–0x9 digit, 0xA start, 0xB stop, 0xC clear, 0xD–0xF ignored.
- cnt_zero  in  NDIG  zero flag of each counter digit; bit 0 is the least-significant digit.
- data  out  4*NDIG  BCD preset to the counters' data inputs; digit 0 is in bits [3:0].
- loadn  out  1  active-low load strobe to all digits.
- en  out  1  count enable to digit 0; one-cycle pulse per tick.
- running  out  1  high while in RUN.
- done  out  1  completion flag.
- alarm  out  1  alarm drive.

## Operation
- States: IDLE, ENTRY, LOAD, RUN, PAUSE, DONE.
- Key priority within a strobe: clear > start/stop > digit. Keys without a listed action in the current state are ignored.
- IDLE:
  - digit → data ← {data[4*NDIG-5:0], key_code}, go to ENTRY.
- ENTRY:
  - digit → shift in the same way; the oldest digit is discarded.
  - clear → data ← 0, go to IDLE.
  - start with data ≠ 0 → go to LOAD. Start with data = 0 is ignored.
- LOAD: loadn = 0 for exactly one cycle with en = 0; prescaler ← 0; then go to RUN.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - Each wrap cycle, if &cnt_zero → go to DONE with no en pulse; otherwise en = 1 for that one cycle.
  - stop → go to PAUSE, prescaler value held.
  - clear → go to IDLE, data ← 0.
- PAUSE:
  - start → go to RUN, prescaler resumes from its held value.
  - clear → go to IDLE, data ← 0.
  - digits are ignored.
- DONE: behaviour is set by TIMER_ALARM_EN (see Configuration).
- Invariants:
  - en is never high while loadn = 0. The counters load only when en is low.
  - en is never pulsed while all cnt_zero bits are high. This prevents the 0→9 wrap.
- data keeps the entered preset through RUN and PAUSE, so a repeat start from DONE→IDLE→ENTRY is not automatic.

## Timing
- Reset values: state IDLE, data 0, loadn 1, en 0, running 0, done 0, alarm 0, prescaler 0. clrn low mid-operation forces these values immediately, without waiting for a clock edge.
- All outputs are registered.
- A key strobe sampled at edge n updates data/state at edge n.
- Start in ENTRY:
  - loadn is low during the cycle after the strobe.
  - running rises the cycle after that.
  - The first en pulse comes TICK_DIV cycles after RUN entry.
- With a preset of P (binary value of BCD), the chain receives exactly P en pulses. done rises at the tick following the last pulse, i.e. TICK_DIV cycles after it.
- cnt_zero is sampled only in prescaler wrap cycles.

## Configuration
- TIMER_ALARM_EN defined:
  - DONE holds done = 1 and alarm = 1 for ALARM_TICKS ticks, timed by the same prescaler, then goes to IDLE.
  - Any key_valid in DONE goes to IDLE at once.
  - On leaving DONE, done and alarm clear.
- TIMER_ALARM_EN undefined:
  - alarm is tied to 0 and ALARM_TICKS has no effect.
  - done is high for exactly one cycle, then the block is in IDLE.

## Test plan
Bench uses TICK_DIV=4, NDIG=4 and a behavioural model of the mod-10 down-counter chain.
- Reset: clrn low mid-RUN → all outputs at reset values within the same cycle; state IDLE after release.
- Entry: keys 1,2,3,4,5 → data = 16'h2345; clear → data = 0, state IDLE.
- Countdown: preset 0x0012, start →
  - loadn low one cycle;
  - 12 en pulses spaced 4 cycles apart;
  - done rises 4 cycles after the last pulse;
  - model count never shows 9 after reaching 0000.
- Pause: stop after 3 pulses → no en for 40 cycles; start → next en arrives with the held prescaler phase; total pulse count stays 12.
- Zero start: start with data = 0 → loadn stays 1, state stays ENTRY/IDLE, no en.
- Alarm: with TIMER_ALARM_EN and ALARM_TICKS=3 → alarm high 12 cycles, then IDLE. Without the macro → done high 1 cycle and alarm stays 0.
